// File: rtl/instr_fetch_requester.sv
// instr_fetch_requester
//   Initiator side of the per-slot instruction fetch protocol. Each
//   reservation-station slot owns a PC and a one-entry instruction
//   buffer. A slot requests a fetch, accepts the tagged response, holds
//   the instruction until the issue stage pops it, then advances its PC
//   by 4 and requests again. Each slot has at most one fetch outstanding.
//
// Ports
//   clk, rst                    clock; asynchronous active-high reset
//   launch_valid/slot/pc        start an IDLE slot at the given PC
//   redirect_valid/slot/pc      branch/jump redirect of one slot
//   reqs, req_pc_vec            per-slot fetch request and its byte PC
//   pc_ack                      one-hot grant from the responder
//   instr_valid, tag, instr     tagged instruction response
//   slot_full, slot_instr,      per-slot buffered instruction and its PC
//   slot_pc
//   issue                       per-slot pop pulses from the issue stage
//
// Optional build macro FETCH_PROTO_CHECK_EN adds:
//   proto_err                   sticky protocol violation flag
//   proto_err_tag               slot/tag of the first violation
module instr_fetch_requester #(
    parameter int NUM_SLOTS = 8,
    parameter int TAG_W     = $clog2(NUM_SLOTS),
    parameter int ADDR_W    = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        launch_valid,
    input  logic [TAG_W-1:0]            launch_slot,
    input  logic [ADDR_W-1:0]           launch_pc,
    input  logic                        redirect_valid,
    input  logic [TAG_W-1:0]            redirect_slot,
    input  logic [ADDR_W-1:0]           redirect_pc,
    output logic [NUM_SLOTS-1:0]        reqs,
    output logic [NUM_SLOTS*ADDR_W-1:0] req_pc_vec,
    input  logic [NUM_SLOTS-1:0]        pc_ack,
    input  logic                        instr_valid,
    input  logic [TAG_W-1:0]            tag,
    input  logic [31:0]                 instr,
    output logic [NUM_SLOTS-1:0]        slot_full,
    output logic [NUM_SLOTS*32-1:0]     slot_instr,
    output logic [NUM_SLOTS*ADDR_W-1:0] slot_pc,
    input  logic [NUM_SLOTS-1:0]        issue
`ifdef FETCH_PROTO_CHECK_EN
    ,
    output logic                        proto_err,
    output logic [TAG_W-1:0]            proto_err_tag
`endif
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_FULL = 2'd3;

    logic [1:0]        state [NUM_SLOTS];
    logic [ADDR_W-1:0] pc    [NUM_SLOTS];
    logic [31:0]       ibuf  [NUM_SLOTS];
    logic [NUM_SLOTS-1:0] drop;

    logic [NUM_SLOTS-1:0] launch_hit;
    logic [NUM_SLOTS-1:0] redir_hit;
    logic [NUM_SLOTS-1:0] resp_hit;

    always_comb begin
        launch_hit = '0;
        redir_hit  = '0;
        resp_hit   = '0;
        for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
            launch_hit[i] = launch_valid   && (launch_slot   == TAG_W'(i));
            redir_hit[i]  = redirect_valid && (redirect_slot == TAG_W'(i));
            resp_hit[i]   = instr_valid    && (tag           == TAG_W'(i));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
                state[i] <= S_IDLE;
                pc[i]    <= '0;
                ibuf[i]  <= '0;
                drop[i]  <= 1'b0;
            end
        end else begin
            for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
                case (state[i])
                    S_IDLE: begin
                        if (launch_hit[i]) begin
                            state[i] <= S_REQ;
                            pc[i]    <= launch_pc;
                        end
                    end
                    S_REQ: begin
                        if (redir_hit[i]) begin
                            pc[i] <= redirect_pc;
                            // A response accepted together with the redirect
                            // belongs to the old PC: drop it and re-request.
                            if (pc_ack[i] && !resp_hit[i]) begin
                                drop[i]  <= 1'b1;
                                state[i] <= S_WAIT;
                            end
                        end else if (pc_ack[i]) begin
                            if (resp_hit[i]) begin
                                state[i] <= S_FULL;
                                ibuf[i]  <= instr;
                            end else begin
                                state[i] <= S_WAIT;
                            end
                        end
                    end
                    S_WAIT: begin
                        if (redir_hit[i]) begin
                            pc[i] <= redirect_pc;
                            if (resp_hit[i]) begin
                                drop[i]  <= 1'b0;
                                state[i] <= S_REQ;
                            end else begin
                                drop[i] <= 1'b1;
                            end
                        end else if (resp_hit[i]) begin
                            drop[i] <= 1'b0;
                            if (drop[i]) begin
                                state[i] <= S_REQ;
                            end else begin
                                state[i] <= S_FULL;
                                ibuf[i]  <= instr;
                            end
                        end
                    end
                    S_FULL: begin
                        // Redirect wins over a same-cycle issue: no +4.
                        if (redir_hit[i]) begin
                            pc[i]    <= redirect_pc;
                            state[i] <= S_REQ;
                        end else if (issue[i]) begin
                            pc[i]    <= pc[i] + ADDR_W'(4);
                            state[i] <= S_REQ;
                        end
                    end
                    default: state[i] <= S_IDLE;
                endcase
            end
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
            reqs[i]                        = (state[i] == S_REQ);
            slot_full[i]                   = (state[i] == S_FULL);
            req_pc_vec[i*ADDR_W +: ADDR_W] = pc[i];
            slot_pc[i*ADDR_W +: ADDR_W]    = pc[i];
            slot_instr[i*32 +: 32]         = ibuf[i];
        end
    end

`ifdef FETCH_PROTO_CHECK_EN
    logic                 accept_any;
    logic [NUM_SLOTS-1:0] bad_ack;
    logic                 multi_ack;
    logic                 bad_found;
    logic                 ack_found;
    logic [TAG_W-1:0]     bad_idx;
    logic [TAG_W-1:0]     ack_idx;
    logic                 err_now;
    logic [TAG_W-1:0]     err_tag;

    always_comb begin
        accept_any = 1'b0;
        bad_ack    = '0;
        bad_found  = 1'b0;
        ack_found  = 1'b0;
        bad_idx    = '0;
        ack_idx    = '0;
        for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
            if (resp_hit[i] && (((state[i] == S_REQ) && pc_ack[i]) || (state[i] == S_WAIT)))
                accept_any = 1'b1;
            bad_ack[i] = pc_ack[i] && (state[i] != S_REQ);
            if (bad_ack[i] && !bad_found) begin
                bad_found = 1'b1;
                bad_idx   = TAG_W'(i);
            end
            if (pc_ack[i] && !ack_found) begin
                ack_found = 1'b1;
                ack_idx   = TAG_W'(i);
            end
        end
        // More than one bit set: clearing the lowest set bit leaves a residue.
        multi_ack = |(pc_ack & (pc_ack - NUM_SLOTS'(1)));
        err_now   = 1'b1;
        err_tag   = '0;
        if (instr_valid && !accept_any) err_tag = tag;
        else if (bad_found)             err_tag = bad_idx;
        else if (multi_ack)             err_tag = ack_idx;
        else                            err_now = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            proto_err     <= 1'b0;
            proto_err_tag <= '0;
        end else if (err_now && !proto_err) begin
            proto_err     <= 1'b1;
            proto_err_tag <= err_tag;
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch_requester.sv
module tb_instr_fetch_requester;

    localparam int NS = 8;
    localparam int TW = 3;
    localparam int AW = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              launch_valid;
    logic [TW-1:0]     launch_slot;
    logic [AW-1:0]     launch_pc;
    logic              redirect_valid;
    logic [TW-1:0]     redirect_slot;
    logic [AW-1:0]     redirect_pc;
    logic [NS-1:0]     reqs;
    logic [NS*AW-1:0]  req_pc_vec;
    logic [NS-1:0]     pc_ack;
    logic              instr_valid;
    logic [TW-1:0]     tag;
    logic [31:0]       instr;
    logic [NS-1:0]     slot_full;
    logic [NS*32-1:0]  slot_instr;
    logic [NS*AW-1:0]  slot_pc;
    logic [NS-1:0]     issue;
`ifdef FETCH_PROTO_CHECK_EN
    logic              proto_err;
    logic [TW-1:0]     proto_err_tag;
`endif

    instr_fetch_requester #(.NUM_SLOTS(NS), .TAG_W(TW), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst),
        .launch_valid(launch_valid), .launch_slot(launch_slot), .launch_pc(launch_pc),
        .redirect_valid(redirect_valid), .redirect_slot(redirect_slot), .redirect_pc(redirect_pc),
        .reqs(reqs), .req_pc_vec(req_pc_vec), .pc_ack(pc_ack),
        .instr_valid(instr_valid), .tag(tag), .instr(instr),
        .slot_full(slot_full), .slot_instr(slot_instr), .slot_pc(slot_pc),
        .issue(issue)
`ifdef FETCH_PROTO_CHECK_EN
        , .proto_err(proto_err), .proto_err_tag(proto_err_tag)
`endif
    );

    always #5 clk = ~clk;

    typedef struct { int unsigned slot; logic [31:0] instr; logic [31:0] pc; } fill_t;
    typedef struct { int unsigned slot; logic [31:0] pc; } req_t;

    fill_t exp_fill[$];
    req_t  exp_req[$];
    int unsigned checks = 0;
    int unsigned passes = 0;
    logic [NS-1:0] prev_full = '0;
    logic [NS-1:0] prev_req  = '0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] expv);
        checks++;
        if (got === expv) passes++;
        else $display("FAIL %s: got %0h required %0h", name, got, expv);
    endtask

    // Monitor: pops the scoreboard whenever a slot fills or starts requesting.
    always @(negedge clk) begin
        if (rst) begin
            prev_full = '0;
            prev_req  = '0;
        end else begin
            for (int i = 0; i < NS; i++) begin
                if (slot_full[i] && !prev_full[i]) begin
                    if (exp_fill.size() == 0) begin
                        checks++;
                        $display("FAIL unexpected_fill: slot %0d filled, required no fill", i);
                    end else begin
                        fill_t e;
                        e = exp_fill.pop_front();
                        chk("fill_slot", 64'(i), 64'(e.slot));
                        chk("fill_instr", 64'(slot_instr[i*32 +: 32]), 64'(e.instr));
                        chk("fill_pc", 64'(slot_pc[i*AW +: AW]), 64'(e.pc));
                    end
                end
                if (reqs[i] && !prev_req[i]) begin
                    if (exp_req.size() == 0) begin
                        checks++;
                        $display("FAIL unexpected_req: slot %0d requested, required no request", i);
                    end else begin
                        req_t r;
                        r = exp_req.pop_front();
                        chk("req_slot", 64'(i), 64'(r.slot));
                        chk("req_pc", 64'(req_pc_vec[i*AW +: AW]), 64'(r.pc));
                    end
                end
            end
            prev_full = slot_full;
            prev_req  = reqs;
        end
    end

    task automatic clr();
        launch_valid = 1'b0; launch_slot = '0; launch_pc = '0;
        redirect_valid = 1'b0; redirect_slot = '0; redirect_pc = '0;
        pc_ack = '0; instr_valid = 1'b0; tag = '0; instr = '0; issue = '0;
    endtask

    task automatic tick();
        @(negedge clk);
        clr();
    endtask

    task automatic check_zero(input string name);
        chk({name, "_reqs"}, 64'(reqs), 64'h0);
        chk({name, "_full"}, 64'(slot_full), 64'h0);
        chk({name, "_instr_or"}, 64'(|slot_instr), 64'h0);
        chk({name, "_pc_or"}, 64'(|slot_pc), 64'h0);
        chk({name, "_reqpc_or"}, 64'(|req_pc_vec), 64'h0);
    endtask

    task automatic do_reset();
        #1 rst = 1'b1;
        @(negedge clk);
        check_zero("reset");
        rst = 1'b0;
    endtask

    task automatic launch(input int unsigned s, input logic [31:0] p);
        launch_valid = 1'b1; launch_slot = TW'(s); launch_pc = p;
        exp_req.push_back('{s, p});
    endtask

    task automatic respond(input int unsigned s, input logic [31:0] d, input logic [31:0] p, input logic ack);
        instr_valid = 1'b1; tag = TW'(s); instr = d;
        if (ack) pc_ack = NS'(1) << s;
        exp_fill.push_back('{s, d, p});
    endtask

    function automatic logic [31:0] rpc(input int unsigned s);
        return req_pc_vec[s*AW +: AW];
    endfunction

    initial begin
        clr();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_zero("por");
        rst = 1'b0;

        // Zero-latency fetch, then issue advances PC by 4.
        launch(2, 32'h100); tick();
        chk("t1_req2", 64'(reqs), 64'h04);
        respond(2, 32'hDEADBEEF, 32'h100, 1'b1); tick();
        chk("t1_full2", 64'(slot_full[2]), 64'h1);
        issue[2] = 1'b1; exp_req.push_back('{2, 32'h104}); tick();
        chk("t1_reqpc2", 64'(rpc(2)), 64'h104);

        // Acked with delayed response.
        launch(5, 32'h200); tick();
        pc_ack = 8'h20; tick();
        chk("t2_wait_req5", 64'(reqs[5]), 64'h0);
        tick(); tick();
        chk("t2_wait_full5", 64'(slot_full[5]), 64'h0);
        respond(5, 32'h12345678, 32'h200, 1'b0); tick();
        chk("t2_full5", 64'(slot_full[5]), 64'h1);

        // Redirect in WAIT discards the stale response.
        launch(1, 32'h300); tick();
        pc_ack = 8'h02; tick();
        redirect_valid = 1'b1; redirect_slot = 3'd1; redirect_pc = 32'h400; tick();
        chk("t3_wait_req1", 64'(reqs[1]), 64'h0);
        instr_valid = 1'b1; tag = 3'd1; instr = 32'hBAD0BAD0;
        exp_req.push_back('{1, 32'h400}); tick();
        chk("t3_stale_full1", 64'(slot_full[1]), 64'h0);
        chk("t3_reqpc1", 64'(rpc(1)), 64'h400);
        respond(1, 32'hC0DE0001, 32'h400, 1'b1); tick();
        chk("t3_full1", 64'(slot_full[1]), 64'h1);

        do_reset();

        // All slots, round-robin grants; slot 3 issues while slot 4 responds.
        for (int k = 0; k < NS; k++) begin
            launch(k, 32'h1000 + 32'(k) * 32'h100); tick();
        end
        chk("t4_all_req", 64'(reqs), 64'hFF);
        for (int k = 0; k < NS; k++) begin
            respond(k, 32'hA0000000 + 32'(k), 32'h1000 + 32'(k) * 32'h100, 1'b1);
            if (k == 4) begin
                issue[3] = 1'b1; exp_req.push_back('{3, 32'h1304});
            end
            tick();
        end
        chk("t4_full_vec", 64'(slot_full), 64'hF7);
        chk("t4_reqpc3", 64'(rpc(3)), 64'h1304);
        for (int k = 0; k < NS; k++)
            if (k != 3) chk("t4_instr", 64'(slot_instr[k*32 +: 32]), 64'hA0000000 + 64'(k));

        do_reset();

        // PC wrap, then redirect beating issue.
        launch(6, 32'hFFFFFFFC); tick();
        respond(6, 32'h6, 32'hFFFFFFFC, 1'b1); tick();
        issue[6] = 1'b1; exp_req.push_back('{6, 32'h0}); tick();
        chk("t5_wrap", 64'(rpc(6)), 64'h0);
        respond(6, 32'h66, 32'h0, 1'b1); tick();
        redirect_valid = 1'b1; redirect_slot = 3'd6; redirect_pc = 32'h800;
        issue[6] = 1'b1; exp_req.push_back('{6, 32'h800}); tick();
        chk("t5_redir_issue", 64'(rpc(6)), 64'h800);

        // Asynchronous reset with slots in WAIT and FULL.
        do_reset();
        launch(0, 32'h40); tick();
        launch(7, 32'h70); pc_ack = 8'h01; tick();
        respond(7, 32'h7, 32'h70, 1'b1); tick();
        chk("t6_pre_full", 64'(slot_full), 64'h80);
        #2 rst = 1'b1;
        #1 check_zero("async");
        @(negedge clk);
        rst = 1'b0;
        instr_valid = 1'b1; tag = 3'd0; instr = 32'h99; tick();
        chk("t6_ignored_full", 64'(slot_full), 64'h0);
        chk("t6_ignored_reqs", 64'(reqs), 64'h0);
`ifdef FETCH_PROTO_CHECK_EN
        chk("t6_proto_err", 64'(proto_err), 64'h1);
        chk("t6_proto_tag", 64'(proto_err_tag), 64'h0);
`endif
        tick();
        chk("sb_fill_drained", 64'(exp_fill.size()), 64'h0);
        chk("sb_req_drained", 64'(exp_req.size()), 64'h0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/instr_fetch_requester.md
Name: instr_fetch_requester

Overview:
Initiator side of the per-slot instruction fetch protocol. Holds one PC per reservation-station slot, raises per-slot fetch requests with PC addresses, and consumes the grant (pcAck) and the tagged instruction response. Buffers one fetched instruction per slot until the issue stage pops it, then advances PC by 4 and re-requests. Sits between the warp/slot launch logic and the instruction memory (arbiter-fronted responder).

Parameters:
NUM_SLOTS, 8, number of slots; equals RSV_CAPACITY.
TAG_W, $clog2(NUM_SLOTS), width of the response tag and slot indices.
ADDR_W, 32, PC / Word_t width; instruction width is also 32.

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
launch_valid  in  1  start a slot
launch_slot  in  TAG_W  slot to start
launch_pc  in  ADDR_W  initial PC
redirect_valid  in  1  branch/jump redirect
redirect_slot  in  TAG_W  slot redirected
redirect_pc  in  ADDR_W  new PC
reqs  out  NUM_SLOTS  per-slot fetch request, registered
req_pc_vec  out  NUM_SLOTS*ADDR_W  per-slot request PC, byte address
pc_ack  in  NUM_SLOTS  one-hot grant; request accepted this cycle
instr_valid  in  1  response valid
tag  in  TAG_W  slot the response belongs to
instr  in  32  fetched instruction
slot_full  out  NUM_SLOTS  buffered instruction available
slot_instr  out  NUM_SLOTS*32  buffered instruction per slot
slot_pc  out  NUM_SLOTS*ADDR_W  PC of buffered instruction
issue  in  NUM_SLOTS  pop buffered instruction, one-cycle pulses

Behaviour:
- Per-slot FSM: IDLE, REQ, WAIT, FULL; per-slot drop bit; only one outstanding fetch per slot.
- Reset (async, any time): all slots IDLE, pc=0, drop=0, buffer=0; reqs=0, slot_full=0, slot_instr=0, slot_pc=0. Responses arriving after reset for pre-reset requests are ignored (slot IDLE).
- reqs[i] = (state==REQ); req_pc_vec[i] = pc[i]; slot_full[i] = (state==FULL); slot_pc[i] = pc[i]. All driven from registers.
- IDLE: launch_valid && launch_slot==i -> REQ, pc<=launch_pc. Launch to a non-IDLE slot is ignored.
- REQ: pc_ack[i] && instr_valid && tag==i in the same cycle -> FULL, latch instr (the responder's normal zero-latency path). pc_ack[i] without a matching response -> WAIT. No ack -> stay REQ, request held stable.
- WAIT: instr_valid && tag==i -> FULL, latch instr; if drop=1, discard instead, clear drop, -> REQ.
- FULL: issue[i] -> REQ, pc<=pc+4 (mod 2^ADDR_W, wraps). issue[i] in any other state is ignored.
- Redirect to slot i, pc<=redirect_pc, drop is set only as stated:
  - IDLE: ignored.
  - REQ, no ack this cycle: stay REQ with the new PC.
  - REQ with ack: drop=1, -> WAIT; if the response arrives the same cycle, discard it and go to REQ.
  - WAIT: drop=1, stay WAIT; if the response arrives the same cycle, discard it and go to REQ.
  - FULL: discard the buffer and go to REQ.
  - Redirect beats issue in the same cycle: no +4.
- A response whose tag slot is not in REQ+ack or WAIT is ignored.
- Slots are independent. Launch, redirect and response can hit different slots in the same cycle.

Optional Feature:
FETCH_PROTO_CHECK_EN: adds outputs proto_err (1, sticky until rst) and proto_err_tag (TAG_W, tag of the first violation). The following set the error:
- a response with no accepting slot;
- pc_ack bit on a slot not in REQ;
- pc_ack not one-hot.
Functional behaviour is unchanged. Without the macro, these ports and their logic are absent.

Test Plan:
- Launch slot 2 at 0x100; ack and response instr=0xDEADBEEF tag=2 in the same cycle -> slot_full[2]=1 next cycle, slot_pc[2]=0x100; issue[2] -> reqs[2]=1 with req_pc 0x104.
- Slot 5 acked with no response, response 3 cycles later with tag=5 -> WAIT held with reqs[5]=0, then FULL with the correct instr.
- Slot 1 in WAIT, redirect to 0x400, then stale response tag=1 -> discarded, slot_full[1]=0, reqs[1]=1 with req_pc 0x400; next response is buffered with slot_pc 0x400.
- All 8 slots launched, responder grants round-robin -> each slot fills exactly once with its own instr, no cross-slot corruption. Issue of slot 3 while slot 4 is responding -> both correct.
- PC 0xFFFFFFFC issued -> next request PC 0x00000000. Redirect and issue to the same FULL slot in the same cycle -> new PC used, no +4.
- Assert rst while slots are in WAIT/FULL -> all outputs 0 immediately; a later response with tag=0 is ignored. Under FETCH_PROTO_CHECK_EN, that response sets proto_err=1 and proto_err_tag=0.
